sar_avg_fifo: RTL and testbench

Downstream stage of the 8-bit SAR conversion controller. Detects each end-of-conversion pulse and captures the conversion result. Averages 2^LOG2_AVG consecutive results by truncating division. Buffers the averages in a small FIFO, which a consumer drains through a valid/ready handshake.

---
 rtl/sar_avg_fifo_if.sv | 12 +
 rtl/sar_avg_fifo.sv | 131 +++++++++++++
 tb/tb_sar_avg_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_avg_fifo_if.sv
// Averaged-sample output stream: valid/ready handshake with the head-of-FIFO data.
// The producer drives valid/data, the consumer drives ready; a beat transfers when both are high.
interface sar_avg_fifo_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sar_avg_fifo.sv
// Captures SAR results on eoc rising edges, averages 2^LOG2_AVG of them and queues the average.
// 1 clk from the final capture to m_valid; a full FIFO drops the new average and sets overflow.
module sar_avg_fifo #(
  parameter int DATA_W     = 8,
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          eoc,
  input  logic [DATA_W-1:0]             sar_data,
  sar_avg_fifo_if.master                m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic              eoc_d_q;
  logic              armed_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              cap;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              valid;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  avg_full;
  logic [DATA_W-1:0] avg;

  // armed_q masks the first edge after reset so an eoc already high then is not seen as a new pulse
  assign cap      = eoc & ~eoc_d_q & enable & armed_q;
  assign sum      = acc_q + ACC_W'(sar_data);
  assign avg_full = sum >> LOG2_AVG;
  assign avg      = avg_full[DATA_W-1:0];
  assign valid    = (level_q != '0);
  assign full     = (level_q == LVL_FULL);
  assign pop      = valid & m.m_ready;
  assign push     = push_req & (~full | pop);

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cap) begin
      if (cnt_q == CNT_LAST) begin
        acc_d    = '0;
        cnt_d    = '0;
        push_req = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // a drop in the same cycle as clr_ovf leaves overflow set
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_d_q  <= 1'b0;
      armed_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      eoc_d_q  <= eoc;
      armed_q  <= 1'b1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= avg;
    end
  end

  assign m.m_valid  = valid;
  assign m.m_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Scoreboard bench: u_a averages 4 samples, u_z passes samples straight through.
// Stimulus pushes hand-computed averages; negedge monitors pop and compare accepted beats.
module tb_sar_avg_fifo;

  logic       clk;
  logic       rst_n;
  logic       enable_a, eoc_a, clr_a;
  logic [7:0] sar_a;
  logic [2:0] lvl_a;
  logic       ovf_a;
  logic       enable_z, eoc_z, clr_z;
  logic [7:0] sar_z;
  logic [2:0] lvl_z;
  logic       ovf_z;

  sar_avg_fifo_if #(.DATA_W(8)) a_if ();
  sar_avg_fifo_if #(.DATA_W(8)) z_if ();

  sar_avg_fifo #(.DATA_W(8), .LOG2_AVG(2), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .eoc(eoc_a), .sar_data(sar_a),
    .m(a_if.master), .fifo_level(lvl_a), .overflow(ovf_a), .clr_ovf(clr_a)
  );

  sar_avg_fifo #(.DATA_W(8), .LOG2_AVG(0), .FIFO_DEPTH(4)) u_z (
    .clk(clk), .rst_n(rst_n), .enable(enable_z), .eoc(eoc_z), .sar_data(sar_z),
    .m(z_if.master), .fifo_level(lvl_z), .overflow(ovf_z), .clr_ovf(clr_z)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_a[$];
  int exp_z[$];
  int ea, ez;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit z, input logic [7:0] d);
    if (z) begin eoc_z = 1'b1; sar_z = d; end
    else   begin eoc_a = 1'b1; sar_a = d; end
    step(1);
    if (z) eoc_z = 1'b0;
    else   eoc_a = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    if (rst_n && a_if.m_valid && a_if.m_ready) begin
      if (exp_a.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_out: got data %0d with no expected entry", a_if.m_data);
      end else begin
        ea = exp_a.pop_front();
        chk("a_data", int'(a_if.m_data), ea);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && z_if.m_valid && z_if.m_ready) begin
      if (exp_z.size() == 0) begin
        n_total++;
        $display("FAIL z_unexpected_out: got data %0d with no expected entry", z_if.m_data);
      end else begin
        ez = exp_z.pop_front();
        chk("z_data", int'(z_if.m_data), ez);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable_a = 1'b1; eoc_a = 1'b0; sar_a = '0; clr_a = 1'b0; a_if.m_ready = 1'b0;
    enable_z = 1'b1; eoc_z = 1'b1; sar_z = 8'd9; clr_z = 1'b0; z_if.m_ready = 1'b0;
    step(2);
    chk("rst_a_valid", int'(a_if.m_valid), 0);
    chk("rst_a_level", int'(lvl_a), 0);
    chk("rst_a_ovf", int'(ovf_a), 0);
    chk("rst_a_data", int'(a_if.m_data), 0);
    chk("rst_z_level", int'(lvl_z), 0);

    // eoc held high across reset release must not capture
    rst_n = 1'b1;
    step(3);
    chk("eoc_thru_rst_no_cap", int'(lvl_z), 0);
    eoc_z = 1'b0;
    step(1);
    exp_z.push_back(9);
    pulse(1'b1, 8'd9);
    chk("eoc_rearm_cap", int'(lvl_z), 1);
    z_if.m_ready = 1'b1;
    step(2);
    z_if.m_ready = 1'b0;

    // four-sample average with 1 clk latency
    a_if.m_ready = 1'b1;
    pulse(1'b0, 8'd10);
    pulse(1'b0, 8'd11);
    pulse(1'b0, 8'd12);
    chk("t1_no_early_valid", int'(a_if.m_valid), 0);
    exp_a.push_back(11);
    eoc_a = 1'b1; sar_a = 8'd13;
    step(1);
    chk("t1_valid_latency", int'(a_if.m_valid), 1);
    eoc_a = 1'b0;
    step(1);
    chk("t1_level_back_0", int'(lvl_a), 0);

    // full-scale sum and truncation
    exp_a.push_back(255);
    repeat (4) pulse(1'b0, 8'd255);
    exp_a.push_back(0);
    pulse(1'b0, 8'd0); pulse(1'b0, 8'd0); pulse(1'b0, 8'd0); pulse(1'b0, 8'd3);
    step(2);
    chk("t2_level", int'(lvl_a), 0);

    // overflow with pass-through samples
    for (int i = 1; i <= 4; i++) begin
      exp_z.push_back(i);
      pulse(1'b1, 8'(i));
    end
    chk("t3_level_full", int'(lvl_z), 4);
    chk("t3_no_ovf_yet", int'(ovf_z), 0);
    pulse(1'b1, 8'd5);
    chk("t3_ovf_set", int'(ovf_z), 1);
    chk("t3_level_kept", int'(lvl_z), 4);
    eoc_z = 1'b1; sar_z = 8'd6; clr_z = 1'b1;
    step(1);
    eoc_z = 1'b0; clr_z = 1'b0;
    step(1);
    chk("t3_set_wins_clr", int'(ovf_z), 1);
    z_if.m_ready = 1'b1;
    step(4);
    chk("t3_drained", int'(lvl_z), 0);
    chk("t3_ovf_sticky", int'(ovf_z), 1);
    clr_z = 1'b1;
    step(1);
    clr_z = 1'b0;
    chk("t3_ovf_cleared", int'(ovf_z), 0);
    z_if.m_ready = 1'b0;

    // long eoc gives exactly one capture
    eoc_z = 1'b1; sar_z = 8'd7;
    step(5);
    eoc_z = 1'b0;
    step(1);
    chk("t4_one_entry", int'(lvl_z), 1);
    exp_z.push_back(7);
    z_if.m_ready = 1'b1;
    step(2);
    chk("t4_drained", int'(lvl_z), 0);

    // pointer wrap over 10 pushes/pops
    for (int i = 0; i < 10; i++) begin
      exp_z.push_back(20 + i);
      pulse(1'b1, 8'(20 + i));
    end
    step(2);
    chk("wrap_level", int'(lvl_z), 0);
    chk("wrap_ovf", int'(ovf_z), 0);

    // disable mid-average discards the partial sum
    pulse(1'b0, 8'd100);
    pulse(1'b0, 8'd100);
    enable_a = 1'b0;
    step(1);
    enable_a = 1'b1;
    exp_a.push_back(40);
    repeat (4) pulse(1'b0, 8'd40);
    step(2);
    chk("t5_level", int'(lvl_a), 0);

    // full FIFO with simultaneous pop and push
    a_if.m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_a.push_back(k);
      repeat (4) pulse(1'b0, 8'(k));
    end
    chk("t6_level_full", int'(lvl_a), 4);
    exp_a.push_back(5);
    repeat (3) pulse(1'b0, 8'd5);
    eoc_a = 1'b1; sar_a = 8'd5; a_if.m_ready = 1'b1;
    step(1);
    eoc_a = 1'b0;
    chk("t6_level_stays_4", int'(lvl_a), 4);
    chk("t6_no_ovf", int'(ovf_a), 0);
    step(6);
    chk("t6_drained", int'(lvl_a), 0);

    for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_z.size() != 0); i++) step(1);
    chk("a_queue_empty", exp_a.size(), 0);
    chk("z_queue_empty", exp_z.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
